hazard_stall_controller: RTL and testbench

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 87 ++++++++
 tb/tb_hazard_stall_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use and HI/LO (mult/div) interlocks, branch flush,
// and a saturating count of stalled cycles.
module hazard_stall_controller #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_IDEX_i,
  input  logic [4:0]  Rt_IDEX_i,
  input  logic [4:0]  Rs_IFID_i,
  input  logic [4:0]  Rt_IFID_i,
  input  logic        branch_taken_i,
  input  logic        md_start_i,
  input  logic        md_is_div_i,
  input  logic        md_use_IFID_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_bubble_o,
  output logic        ifid_flush_o,
  output logic        md_busy_o,
  output logic        md_done_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 1);

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [15:0] stall_cnt;
  logic        load_hazard, md_hazard, stall;

  assign load_hazard = mem_read_IDEX_i && (Rt_IDEX_i != 5'd0) &&
                       ((Rt_IDEX_i == Rs_IFID_i) || (Rt_IDEX_i == Rt_IFID_i));
  assign md_hazard   = (state == MD_WAIT) && md_use_IFID_i;

  // Gating with reset keeps the pipeline enables at their idle values while reset is held.
  assign stall         = reset && (load_hazard || md_hazard);
  assign pc_write_o    = !stall;
  assign ifid_write_o  = !stall;
  assign idex_bubble_o = stall;
  assign ifid_flush_o  = reset && branch_taken_i && !stall;

  assign md_busy_o      = (state == MD_WAIT);
  assign stall_cycles_o = stall_cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_done_o = 1'b0;
    case (state)
      RUN: begin
        if (md_start_i) begin
          state_nxt = MD_WAIT;
          cnt_nxt   = md_is_div_i ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_WAIT: begin
        // A new md_start_i here is deliberately ignored; the unit is single-issue.
        if (cnt == 6'd0) begin
          md_done_o = 1'b1;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= 6'd0;
      stall_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: vector table for the combinational
// hazard logic plus hand-written multi-cycle sequences for mult/div and reset.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_IDEX_i;
  logic [4:0]  Rt_IDEX_i, Rs_IFID_i, Rt_IFID_i;
  logic        branch_taken_i, md_start_i, md_is_div_i, md_use_IFID_i;
  logic        pc_write_o, ifid_write_o, idex_bubble_o, ifid_flush_o;
  logic        md_busy_o, md_done_o;
  logic [15:0] stall_cycles_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall_cnt = 0;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MULT_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset),
    .mem_read_IDEX_i(mem_read_IDEX_i), .Rt_IDEX_i(Rt_IDEX_i),
    .Rs_IFID_i(Rs_IFID_i), .Rt_IFID_i(Rt_IFID_i),
    .branch_taken_i(branch_taken_i), .md_start_i(md_start_i),
    .md_is_div_i(md_is_div_i), .md_use_IFID_i(md_use_IFID_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_bubble_o(idex_bubble_o), .ifid_flush_o(ifid_flush_o),
    .md_busy_o(md_busy_o), .md_done_o(md_done_o),
    .stall_cycles_o(stall_cycles_o)
  );

  typedef struct {
    logic       mem_read;
    logic [4:0] rt_idex;
    logic [4:0] rs_ifid;
    logic [4:0] rt_ifid;
    logic       branch;
    logic       md_use;
    logic       exp_pc;
    logic       exp_ifid;
    logic       exp_bubble;
    logic       exp_flush;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read_IDEX_i = 0; Rt_IDEX_i = 0; Rs_IFID_i = 0; Rt_IFID_i = 0;
    branch_taken_i = 0; md_start_i = 0; md_is_div_i = 0; md_use_IFID_i = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pc_write"}, pc_write_o, 1);
    check({tag, "_ifid_write"}, ifid_write_o, 1);
    check({tag, "_bubble"}, idex_bubble_o, 0);
    check({tag, "_flush"}, ifid_flush_o, 0);
    check({tag, "_busy"}, md_busy_o, 0);
    check({tag, "_done"}, md_done_o, 0);
    check({tag, "_stall_cnt"}, stall_cycles_o, 0);
  endtask

  initial begin
    int busy_cnt, done_cnt, done_idx, stall_seen, i;

    vecs[0] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};   // idle
    vecs[1] = '{1, 5, 5, 0, 0, 0, 0, 0, 1, 0};   // load-use on Rs
    vecs[2] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0};   // register zero never hazards
    vecs[3] = '{1, 7, 2, 7, 0, 0, 0, 0, 1, 0};   // load-use on Rt
    vecs[4] = '{1, 7, 3, 4, 0, 0, 1, 1, 0, 0};   // load, no match
    vecs[5] = '{0, 5, 5, 5, 0, 0, 1, 1, 0, 0};   // match but not a load
    vecs[6] = '{0, 0, 1, 2, 1, 0, 1, 1, 0, 1};   // taken branch flushes
    vecs[7] = '{1, 9, 9, 0, 1, 0, 0, 0, 1, 0};   // stall beats flush
    vecs[8] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};   // md_use with unit idle
    vecs[9] = '{1, 31, 0, 31, 1, 1, 0, 0, 1, 0}; // r31 load-use with branch

    // Reset with hazardous inputs applied
    clear_inputs();
    mem_read_IDEX_i = 1; Rt_IDEX_i = 5; Rs_IFID_i = 5; branch_taken_i = 1; md_start_i = 1;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    clear_inputs();
    reset = 1;

    // Combinational vector table in RUN
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      mem_read_IDEX_i = vecs[v].mem_read;
      Rt_IDEX_i       = vecs[v].rt_idex;
      Rs_IFID_i       = vecs[v].rs_ifid;
      Rt_IFID_i       = vecs[v].rt_ifid;
      branch_taken_i  = vecs[v].branch;
      md_use_IFID_i   = vecs[v].md_use;
      #1;
      check($sformatf("vec%0d_pc_write", v), pc_write_o, vecs[v].exp_pc);
      check($sformatf("vec%0d_ifid_write", v), ifid_write_o, vecs[v].exp_ifid);
      check($sformatf("vec%0d_bubble", v), idex_bubble_o, vecs[v].exp_bubble);
      check($sformatf("vec%0d_flush", v), ifid_flush_o, vecs[v].exp_flush);
      @(posedge clk);
      #1;
      if (vecs[v].exp_bubble) exp_stall_cnt++;
      check($sformatf("vec%0d_stall_cnt", v), stall_cycles_o, exp_stall_cnt);
    end

    // Branch held across a load stall: flush deferred one cycle
    @(negedge clk);
    clear_inputs();
    mem_read_IDEX_i = 1; Rt_IDEX_i = 12; Rs_IFID_i = 12; branch_taken_i = 1;
    #1;
    check("br_stall_flush", ifid_flush_o, 0);
    check("br_stall_pc", pc_write_o, 0);
    exp_stall_cnt++;
    @(negedge clk);
    mem_read_IDEX_i = 0;
    #1;
    check("br_next_flush", ifid_flush_o, 1);
    check("br_next_pc", pc_write_o, 1);

    // Multiply followed by a dependent mfhi/mflo
    @(negedge clk);
    clear_inputs();
    md_start_i = 1; md_is_div_i = 0;
    #1;
    check("mul_issue_busy", md_busy_o, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      md_start_i = 0; md_use_IFID_i = 1;
      #1;
      check($sformatf("mul_c%0d_busy", c), md_busy_o, 1);
      check($sformatf("mul_c%0d_done", c), md_done_o, (c == 3));
      check($sformatf("mul_c%0d_pc", c), pc_write_o, 0);
      check($sformatf("mul_c%0d_bubble", c), idex_bubble_o, 1);
      exp_stall_cnt++;
    end
    @(negedge clk);
    #1;
    check("mul_rel_busy", md_busy_o, 0);
    check("mul_rel_done", md_done_o, 0);
    check("mul_rel_pc", pc_write_o, 1);
    check("mul_stall_cnt", stall_cycles_o, exp_stall_cnt);

    // Divide without dependency, with a second start mid-divide
    @(negedge clk);
    clear_inputs();
    md_start_i = 1; md_is_div_i = 1;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; stall_seen = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      md_start_i = (i == 10);
      #1;
      if (!md_busy_o) break;
      busy_cnt++;
      if (md_done_o) begin done_cnt++; done_idx = i; end
      if (!pc_write_o) stall_seen++;
    end
    md_start_i = 0;
    check("div_terminated", (i < 100), 1);
    check("div_busy_cycles", busy_cnt, 32);
    check("div_done_pulses", done_cnt, 1);
    check("div_done_last", done_idx, 31);
    check("div_no_stall", stall_seen, 0);
    check("div_stall_cnt", stall_cycles_o, exp_stall_cnt);

    // Reset in the 10th divide cycle
    @(negedge clk);
    clear_inputs();
    md_start_i = 1; md_is_div_i = 1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      md_start_i = 0;
    end
    @(negedge clk);
    md_use_IFID_i = 1; mem_read_IDEX_i = 1; Rt_IDEX_i = 5; Rs_IFID_i = 5; branch_taken_i = 1;
    #1;
    check("rst10_busy_before", md_busy_o, 1);
    #1;
    reset = 0;
    #1;
    exp_stall_cnt = 0;
    check_idle_outputs("rst10");
    @(negedge clk);
    mem_read_IDEX_i = 0; branch_taken_i = 0;
    reset = 1;
    busy_cnt = 0; done_cnt = 0; stall_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md_busy_o) busy_cnt++;
      if (md_done_o) done_cnt++;
      if (!pc_write_o) stall_seen++;
    end
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_done", done_cnt, 0);
    check("post_rst_stall", stall_seen, 0);
    check("post_rst_stall_cnt", stall_cycles_o, exp_stall_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
